// File: rtl/ps2_scancode_rx_pkg.sv
// Shared types and constants for the PS/2 scancode receiver slice.
// Frame layout in the shift register after 11 captures: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } ps2_state_e;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_ENTRY_W    = 10;
    localparam int unsigned PS2_FRAME_W    = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    // Start low, stop high, odd parity over data plus parity bit.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_W-1:0] f);
        return ~f[0] & f[10] & (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_entry_fifo.sv
// Synchronous-reset FIFO with valid/ready pop, sticky overflow on dropped pushes.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module ps2_entry_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             overflow_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, pop, wr_en;

    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop   = ~empty & ready_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en = push_i & (~full | pop);
        wr_d  = wr_en ? wr_q + PTR_ONE : wr_q;
        rd_d  = pop   ? rd_q + PTR_ONE : rd_q;
        ovf_d = ovf_q | (push_i & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        valid_o    = ~empty;
        rdata_o    = empty ? '0 : mem_q[rd_q[AW-1:0]];
        overflow_o = ovf_q;
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin synchronizer, frame FSM with timeout, E0/F0 prefix folding,
// and a small entry FIFO feeding the scancode lookup.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_break,
    output logic       out_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE = TW'(1);

    logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic fall;

    ps2_state_e             state_q, state_d;
    logic [PS2_FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [TW-1:0]          to_q, to_d;
    logic                   ext_q, ext_d, brk_q, brk_d;

    logic       push;
    ps2_entry_t push_entry, head;
    logic [7:0] code;

    // Pins idle high, so the synchronizer resets high to avoid a false fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;
    assign code = shift_q[8:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        to_d    = '0;
        ext_d   = ext_q;
        brk_d   = brk_q;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[PS2_FRAME_W-1:1]};
                    cnt_d   = 4'd1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[PS2_FRAME_W-1:1]};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd10) state_d = S_CHECK;
                end else if (to_q == TO_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (ps2_frame_ok(shift_q) && code == PS2_PREFIX_EXT) begin
                    ext_d = 1'b1;
                end else if (ps2_frame_ok(shift_q) && code == PS2_PREFIX_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_err  = 1'b0;
        push       = 1'b0;
        push_entry = '{ext: ext_q, brk: brk_q, code: code};
        if (state_q == S_SHIFT) begin
            frame_err = ~fall & (to_q == TO_MAX);
        end else if (state_q == S_CHECK) begin
            frame_err = ~ps2_frame_ok(shift_q);
            push      = ps2_frame_ok(shift_q) && code != PS2_PREFIX_EXT && code != PS2_PREFIX_BRK;
        end
    end

    ps2_entry_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PS2_ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .wdata_i    (push_entry),
        .valid_o    (out_valid),
        .ready_i    (out_ready),
        .rdata_o    (head),
        .overflow_o (overflow)
    );

    assign out_code  = head.code;
    assign out_break = head.brk;
    assign out_ext   = head.ext;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: PS/2 frames at 40 clk per bit, hand-computed expectations.
module tb_ps2_scancode_rx;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, out_ready;
    logic       out_valid, out_break, out_ext, frame_err, overflow;
    logic [7:0] out_code;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int wide_cnt = 0;
    logic err_prev = 1'b0;
    int e0;

    always #5 clk = ~clk;

    ps2_scancode_rx #(
        .DEPTH   (8),
        .TIMEOUT (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_break (out_break),
        .out_ext   (out_ext),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (frame_err && err_prev) wide_cnt++;
        err_prev = frame_err;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] c, input logic bad_par);
        return {1'b1, (~^c) ^ bad_par, c, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (20) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic send_code(input logic [7:0] c);
        send_bits(mk_frame(c, 1'b0), 11);
    endtask

    // Raises out_ready for exactly the posedge on which the final bit's push lands.
    task automatic send_code_pop_on_push(input logic [7:0] c);
        logic [10:0] f;
        f = mk_frame(c, 1'b0);
        send_bits(f, 10);
        @(negedge clk) ps2_data = f[10];
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (16) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] c, input logic brk, input logic ext);
        @(negedge clk);
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_code"}, out_code, c);
        check_eq({tag, "_brk"}, out_break, brk);
        check_eq({tag, "_ext"}, out_ext, ext);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_code", out_code, 8'h00);
        check_eq("rst_brk", out_break, 1'b0);
        check_eq("rst_ext", out_ext, 1'b0);
        check_eq("rst_err", frame_err, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);

        // 1: literal 0x1C frame, bits b0..b10 = 0,0,0,1,1,1,0,0,0,0,1
        e0 = err_cnt;
        send_bits(11'b100_0011_1000, 11);
        check_eq("t1_err_none", err_cnt - e0, 0);
        pop_expect("t1", 8'h1C, 1'b0, 1'b0);
        check_eq("t1_empty", out_valid, 1'b0);

        // 2: prefix folding
        send_code(8'hF0);
        check_eq("t2_f0_nopush", out_valid, 1'b0);
        send_code(8'h1C);
        pop_expect("t2_brk", 8'h1C, 1'b1, 1'b0);
        check_eq("t2_one_entry", out_valid, 1'b0);
        send_code(8'hE0);
        send_code(8'hF0);
        send_code(8'h75);
        pop_expect("t2_extbrk", 8'h75, 1'b1, 1'b1);
        check_eq("t2b_one_entry", out_valid, 1'b0);

        // 3: parity error clears pending prefixes
        send_code(8'hF0);
        e0 = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        check_eq("t3_err_pulse", err_cnt - e0, 1);
        check_eq("t3_err_width", wide_cnt, 0);
        check_eq("t3_nopush", out_valid, 1'b0);
        send_code(8'h1C);
        pop_expect("t3_after", 8'h1C, 1'b0, 1'b0);

        // 4: overflow on the ninth entry, then in-order drain
        for (int i = 1; i <= 9; i++) send_code(8'(i));
        check_eq("t4_ovf", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("t4_drain%0d", i), 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        check_eq("t4_empty", out_valid, 1'b0);
        check_eq("t4_ovf_sticky", overflow, 1'b1);

        // 5: truncated frame times out
        e0 = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b0), 5);
        repeat (300) @(negedge clk);
        check_eq("t5_timeout_pulse", err_cnt - e0, 1);
        check_eq("t5_err_width", wide_cnt, 0);
        check_eq("t5_nopush", out_valid, 1'b0);
        send_code(8'h1C);
        pop_expect("t5_after", 8'h1C, 1'b0, 1'b0);

        // 6: reset mid-frame with queued entries
        send_code(8'h11);
        send_code(8'h22);
        send_code(8'h33);
        send_bits(mk_frame(8'h5A, 1'b0), 5);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_eq("t6_valid", out_valid, 1'b0);
        check_eq("t6_code", out_code, 8'h00);
        check_eq("t6_brk", out_break, 1'b0);
        check_eq("t6_ext", out_ext, 1'b0);
        check_eq("t6_ovf", overflow, 1'b0);
        check_eq("t6_err", frame_err, 1'b0);
        send_code(8'h5A);
        pop_expect("t6_5a", 8'h5A, 1'b0, 1'b0);
        check_eq("t6_empty", out_valid, 1'b0);

        // 6b: full FIFO, push and pop in the same cycle
        for (int i = 0; i < 8; i++) send_code(8'h31 + 8'(i));
        @(negedge clk);
        check_eq("t6b_head", out_code, 8'h31);
        send_code_pop_on_push(8'h39);
        check_eq("t6b_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("t6b_drain%0d", i), 8'h32 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        check_eq("t6b_empty", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
